// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: data width,
// ALU op codes and the scheduler state encoding.
package alu_sched_pkg;

  localparam int W = 12;

  localparam logic [2:0] OP_ABS = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_alu.sv
// Purely combinational 12-bit ALU. Its raw carry is op-dependent and is
// cleaned up by the scheduler before it reaches the response channel.
module alu
  import alu_sched_pkg::*;
(
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z,
  output logic         carry
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    z     = '0;
    carry = 1'b0;
    case (op)
      OP_ABS: begin
        z     = a[W-1] ? (~a + 12'd1) : a;
        carry = a[W-1];
      end
      OP_SHL: begin
        z     = {b[W-2:0], 1'b0};
        carry = b[W-1];
      end
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_XOR: z = a ^ b;
      OP_NOT: z = ~a;
      OP_ADD: begin
        z     = sum[W-1:0];
        carry = sum[W];
      end
      OP_SUB: begin
        z     = diff[W-1:0];
        carry = diff[W];
      end
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two command ports: arbitrate in IDLE, execute from
// registered operands in EXEC, hold the normalized result in RESP.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_z,
  output logic         rsp_carry,
  output logic         rsp_sign,
  output logic         rsp_ov,
  output logic [15:0]  ops_done
);

  state_t       state;
  logic         last_grant;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         id_q;
  logic         gnt;
  logic         accept_ok;
  logic [W-1:0] alu_z;
  logic         alu_carry;
  logic         carry_n;
  logic         ov_n;

  // gnt = 1 selects port 1; a tie goes to the port not served last time
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = RR_EN ? ~last_grant : 1'b0;
    else                          gnt = req1_valid;
  end

  assign accept_ok  = (state == IDLE) && !rst;
  assign req0_ready = accept_ok && req0_valid && !gnt;
  assign req1_ready = accept_ok && req1_valid && gnt;

  alu u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .z     (alu_z),
    .carry (alu_carry)
  );

  // Carry and overflow are only meaningful for add/sub; forced low otherwise
  always_comb begin
    carry_n = 1'b0;
    ov_n    = 1'b0;
    case (op_q)
      OP_ADD: begin
        carry_n = alu_carry;
        ov_n    = (a_q[W-1] == b_q[W-1]) && (alu_z[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        carry_n = alu_carry;
        ov_n    = (a_q[W-1] != b_q[W-1]) && (alu_z[W-1] != a_q[W-1]);
      end
      default: begin
        carry_n = 1'b0;
        ov_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_z      <= '0;
      rsp_carry  <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_ov     <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            op_q       <= gnt ? req1_op : req0_op;
            a_q        <= gnt ? req1_a  : req0_a;
            b_q        <= gnt ? req1_b  : req0_b;
            id_q       <= gnt;
            last_grant <= gnt;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_z     <= alu_z;
          rsp_carry <= carry_n;
          rsp_sign  <= alu_z[W-1];
          rsp_ov    <= ov_n;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, multi-cycle
// corner sequences and random commands checked against an arithmetic model.
module tb_alu_sched;

  typedef struct {
    logic [11:0] z;
    logic        c;
    logic        s;
    logic        o;
  } res_t;

  typedef struct {
    bit          port;
    logic [2:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] z;
    logic        c;
    logic        s;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [11:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_sign, rsp_ov;
  logic [11:0] rsp_z;
  logic [15:0] ops_done;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic        fp_rsp_carry, fp_rsp_sign, fp_rsp_ov;
  logic [11:0] fp_rsp_z;
  logic [15:0] fp_ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_sched #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .rsp_ov(rsp_ov),
    .ops_done(ops_done)
  );

  alu_sched #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_z(fp_rsp_z), .rsp_carry(fp_rsp_carry), .rsp_sign(fp_rsp_sign), .rsp_ov(fp_rsp_ov),
    .ops_done(fp_ops_done)
  );

  // Reference: signed/unsigned integer arithmetic, then truncate to 12 bits
  function automatic res_t refModel(input int op, input int a, input int b);
    res_t r;
    int sa, sb, full, sfull;
    sa = (a >= 2048) ? a - 4096 : a;
    sb = (b >= 2048) ? b - 4096 : b;
    full = 0;
    r.c = 1'b0;
    r.o = 1'b0;
    case (op)
      0: full = (sa < 0) ? -sa : sa;
      1: full = b * 2;
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = 4095 - a;
      6: begin
        full  = a + b;
        r.c   = (full > 4095);
        sfull = sa + sb;
        r.o   = (sfull > 2047) || (sfull < -2048);
      end
      default: begin
        full  = a - b;
        r.c   = (a < b);
        sfull = sa - sb;
        r.o   = (sfull > 2047) || (sfull < -2048);
      end
    endcase
    r.z = 12'(full & 4095);
    r.s = r.z[11];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen
  task automatic applyStimulus(input bit port, input logic [2:0] op,
                               input logic [11:0] a, input logic [11:0] b,
                               output int lat);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: port %0d never granted", port);
    end
    lat = 0;
    do begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic checkResp(input res_t e, input bit port, input int lat, input string tag);
    checkOutput({tag, "_valid"}, rsp_valid, 1);
    checkOutput({tag, "_latency"}, lat, 2);
    checkOutput({tag, "_z"}, rsp_z, e.z);
    checkOutput({tag, "_carry"}, rsp_carry, e.c);
    checkOutput({tag, "_sign"}, rsp_sign, e.s);
    checkOutput({tag, "_ov"}, rsp_ov, e.o);
    checkOutput({tag, "_id"}, rsp_id, port);
  endtask

  task automatic releaseResp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    checkOutput({tag, "_ops_done"}, ops_done, exp_ops);
    checkOutput({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[12];
    res_t e;
    int   lat;
    int   q_rr[$];
    int   q_fp[$];
    bit   both_ready;
    bit   port;
    logic [2:0]  op;
    logic [11:0] a, b;

    vecs[0]  = '{1'b0, 3'd6, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 3'd7, 12'h000, 12'h001, 12'hFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 12'h000, 12'h801, 12'h002, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 12'h800, 12'h123, 12'h800, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'd0, 12'hFFE, 12'h000, 12'h002, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 12'h0F0, 12'h000, 12'hF0F, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 3'd4, 12'hAAA, 12'hFFF, 12'h555, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd3, 12'hA00, 12'h00A, 12'hA0A, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 3'd6, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd7, 12'h800, 12'h001, 12'h7FF, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 3'd6, 12'h800, 12'h800, 12'h000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 12'h001; req0_b = 12'h002;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 12'h000; req1_b = 12'h000;
    #2;
    checkOutput("reset_req0_ready", req0_ready, 0);
    checkOutput("reset_req1_ready", req1_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_z", rsp_z, 0);
    checkOutput("reset_flags", {rsp_carry, rsp_sign, rsp_ov}, 0);
    checkOutput("reset_ops_done", ops_done, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      e.z = vecs[i].z; e.c = vecs[i].c; e.s = vecs[i].s; e.o = vecs[i].o;
      checkResp(e, vecs[i].port, lat, $sformatf("vec%0d", i));
      releaseResp($sformatf("vec%0d", i));
    end

    $display("[TB] back-pressure hold");
    applyStimulus(1'b0, 3'd6, 12'h7FF, 12'h001, lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", i), rsp_valid, 1);
      checkOutput($sformatf("bp%0d_z", i), rsp_z, 12'h800);
      checkOutput($sformatf("bp%0d_flags", i), {rsp_carry, rsp_sign, rsp_ov, rsp_id}, 4'b0110);
      checkOutput($sformatf("bp%0d_readies", i), {req0_ready, req1_ready}, 0);
      checkOutput($sformatf("bp%0d_ops_done", i), ops_done, exp_ops);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    releaseResp("bp");

    $display("[TB] tie arbitration, round-robin and fixed priority");
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 12'h010; req0_b = 12'h001;
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 12'h010; req1_b = 12'h001;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    both_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) q_rr.push_back(int'(rsp_id));
      if (fp_rsp_valid) q_fp.push_back(int'(fp_rsp_id));
      if ((req0_ready && req1_ready) || (fp_req0_ready && fp_req1_ready)) both_ready = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    exp_ops = 4;
    checkOutput("rr_ops_done", ops_done, 4);
    checkOutput("fp_ops_done", fp_ops_done, 4);
    checkOutput("rr_count", q_rr.size(), 4);
    checkOutput("fp_count", q_fp.size(), 4);
    checkOutput("both_ready", both_ready, 0);
    for (int i = 0; i < q_rr.size() && i < 4; i++)
      checkOutput($sformatf("rr_id%0d", i), q_rr[i], i % 2);
    for (int i = 0; i < q_fp.size() && i < 4; i++)
      checkOutput($sformatf("fp_id%0d", i), q_fp[i], 0);
    @(negedge clk);

    $display("[TB] reset during RESP");
    applyStimulus(1'b0, 3'd4, 12'h0F0, 12'h00F, lat);
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 12'h100; req1_b = 12'h023;
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_valid", rsp_valid, 0);
    checkOutput("rstmid_ops_done", ops_done, 0);
    checkOutput("rstmid_z", rsp_z, 0);
    checkOutput("rstmid_req1_ready", req1_ready, 0);
    exp_ops = 0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd6, 12'h100, 12'h023, lat);
    checkResp(refModel(6, 'h100, 'h023), 1'b1, lat, "rstmid_p1");
    releaseResp("rstmid_p1");

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      port = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      a    = 12'($urandom);
      b    = 12'($urandom);
      e    = refModel(int'(op), int'(a), int'(b));
      applyStimulus(port, op, a, b, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checkResp(e, port, lat, $sformatf("rand%0d", i));
      releaseResp($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
